// File: rtl/rffe_slave_if.sv
// rffe_slave_if: bus-side signal bundle for the RFFE slave.
// Carries the SCLK/SDATA pad signals, the register-write strobe group,
// the frame error strobe, the host-side register inspect port and the
// FSM state for observation.
//
// Handshake: wr_vd is a one-clk valid strobe with no ready; wr_addr and
// wr_data are valid in the same clk as wr_vd and hold afterwards. The
// consumer must take the write in that clk, it cannot apply backpressure.
interface rffe_slave_if;
  logic       sclk;
  logic       sdi;
  logic       sdo;
  logic       sdo_en;
  logic       wr_vd;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [2:0] fsm_state;

  modport slave (
    input  sclk, sdi, dbg_addr,
    output sdo, sdo_en, wr_vd, wr_addr, wr_data, frame_err, dbg_data, fsm_state
  );

  modport master (
    output sclk, sdi, dbg_addr,
    input  sdo, sdo_en, wr_vd, wr_addr, wr_data, frame_err, dbg_data, fsm_state
  );
endinterface

// File: rtl/rffe_slave.sv
// rffe_slave: MIPI RFFE slave with a 32x8 register file.
// Supports Register Write and Register Read; SCLK and SDATA are
// oversampled by clk through SYNC_STAGES-deep synchronizers.
// Optional feature: define RFFE_REG0_WR_EN to compile in the
// Register 0 Write command (CMD[7]==1 writes REG0 = CMD[6:0]).
module rffe_slave #(
  parameter logic [3:0] USID        = 4'hF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  rffe_slave_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SSC   = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_TA    = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_PARK  = 3'd6;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_cur, sclk_old, sdi_cur, sdi_old;
  logic                   sclk_rise, sclk_fall, sdi_rise, sdi_fall;
  logic                   ssc_start;

  logic [2:0]  state;
  logic [3:0]  bit_cnt;
  logic [11:0] shift_sr;
  logic [4:0]  addr;
  logic [8:0]  rd_sh;
  logic        ta_seen;
  logic [7:0]  regs [32];

  logic        sdo, sdo_en, wr_vd, frame_err;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;

  logic [12:0] cmd_word;
  logic [3:0]  cmd_sa;
  logic [7:0]  cmd_op;
  logic [8:0]  data_word;
  logic        cmd_par_ok, data_par_ok;
  logic        sa_direct, sa_bcast, is_wr, is_rd;
  logic        in_frame;

  // Input synchronizers: shift pad levels toward the MSB each clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
    end
  end

  // Edge events come from the last two stages; the newer one is the level.
  assign sclk_cur  = sclk_sync[SYNC_STAGES-2];
  assign sclk_old  = sclk_sync[SYNC_STAGES-1];
  assign sdi_cur   = sdi_sync[SYNC_STAGES-2];
  assign sdi_old   = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_cur & ~sclk_old;
  assign sclk_fall = ~sclk_cur & sclk_old;
  assign sdi_rise  = sdi_cur & ~sdi_old;
  assign sdi_fall  = ~sdi_cur & sdi_old;
  // SDATA only moves while SCLK is high inside a frame, so a rise with
  // SCLK low can only be the start of a sequence start condition.
  assign ssc_start = sdi_rise & ~sclk_cur;

  // Decode views of the shift register plus the bit sampled this fall.
  assign cmd_word    = {shift_sr, sdi_cur};
  assign cmd_sa      = cmd_word[12:9];
  assign cmd_op      = cmd_word[8:1];
  assign cmd_par_ok  = ^cmd_word;
  assign data_word   = {shift_sr[7:0], sdi_cur};
  assign data_par_ok = ^data_word;
  assign sa_direct   = (cmd_sa == USID);
  assign sa_bcast    = (cmd_sa == 4'h0);
  assign is_wr       = (cmd_op[7:5] == 3'b010);
  assign is_rd       = (cmd_op[7:5] == 3'b011);
  assign in_frame    = (state == S_SSC) || (state == S_CMD) ||
                       (state == S_WDATA) || (state == S_TA);

  // Frame FSM, register file, write strobe and SDATA drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_sr  <= '0;
      addr      <= '0;
      rd_sh     <= '0;
      ta_seen   <= 1'b0;
      sdo       <= 1'b0;
      sdo_en    <= 1'b0;
      wr_vd     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      wr_vd     <= 1'b0;
      frame_err <= 1'b0;
      if (ssc_start && in_frame) begin
        // A new start condition mid-frame aborts the current frame.
        frame_err <= 1'b1;
        state     <= S_SSC;
      end else begin
        case (state)
          S_IDLE: begin
            if (ssc_start) state <= S_SSC;
          end
          S_SSC: begin
            if (sclk_rise) begin
              state <= S_IDLE;
            end else if (sdi_fall && !sclk_cur) begin
              state   <= S_CMD;
              bit_cnt <= '0;
            end
          end
          S_CMD: begin
            if (sclk_fall) begin
              if (bit_cnt == 4'd12) begin
                if (!cmd_par_ok) begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
                end else if (is_wr && (sa_direct || sa_bcast)) begin
                  addr    <= cmd_op[4:0];
                  bit_cnt <= '0;
                  state   <= S_WDATA;
                end else if (is_rd && sa_direct) begin
                  rd_sh   <= {regs[cmd_op[4:0]], ~^regs[cmd_op[4:0]]};
                  ta_seen <= 1'b0;
                  state   <= S_TA;
`ifdef RFFE_REG0_WR_EN
                end else if (cmd_op[7] && (sa_direct || sa_bcast)) begin
                  regs[0] <= {1'b0, cmd_op[6:0]};
                  wr_vd   <= 1'b1;
                  wr_addr <= 5'd0;
                  wr_data <= {1'b0, cmd_op[6:0]};
                  state   <= S_PARK;
`endif
                end else begin
                  state <= S_IDLE;
                end
              end else begin
                shift_sr <= {shift_sr[10:0], sdi_cur};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          S_WDATA: begin
            if (sclk_fall) begin
              if (bit_cnt == 4'd8) begin
                if (data_par_ok) begin
                  regs[addr] <= data_word[8:1];
                  wr_vd      <= 1'b1;
                  wr_addr    <= addr;
                  wr_data    <= data_word[8:1];
                  state      <= S_PARK;
                end else begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
                end
              end else begin
                shift_sr <= {shift_sr[10:0], sdi_cur};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          S_TA: begin
            // One full SCLK period (rise..fall) of bus turnaround, then
            // the slave starts driving D7 on the following rise.
            if (sclk_fall) begin
              ta_seen <= 1'b1;
            end else if (sclk_rise && ta_seen) begin
              sdo     <= rd_sh[8];
              rd_sh   <= {rd_sh[7:0], 1'b0};
              sdo_en  <= 1'b1;
              bit_cnt <= 4'd1;
              state   <= S_RDATA;
            end
          end
          S_RDATA: begin
            if (sclk_rise && (bit_cnt < 4'd9)) begin
              sdo     <= rd_sh[8];
              rd_sh   <= {rd_sh[7:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (sclk_fall && (bit_cnt == 4'd9)) begin
              // Parity has been sampled: park the bus low, still driving.
              sdo   <= 1'b0;
              state <= S_PARK;
            end
          end
          S_PARK: begin
            if (sclk_fall) begin
              sdo    <= 1'b0;
              sdo_en <= 1'b0;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.sdo       = sdo;
  assign bus.sdo_en    = sdo_en;
  assign bus.wr_vd     = wr_vd;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.frame_err = frame_err;
  assign bus.dbg_data  = regs[bus.dbg_addr];
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_rffe_slave.sv
// tb_rffe_slave: directed bench for rffe_slave (USID=4'hF).
// Expectations for the REG0 command follow RFFE_REG0_WR_EN.
module tb_rffe_slave;

  logic clk;
  logic rst;
  rffe_slave_if bus ();

  rffe_slave #(.USID(4'hF), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Event counters observed on the falling clk edge
  int         wr_cnt   = 0;
  int         ferr_cnt = 0;
  int         en_cnt   = 0;
  logic [4:0] last_addr = '0;
  logic [7:0] last_data = '0;

  always @(negedge clk) begin
    if (bus.wr_vd === 1'b1) begin
      wr_cnt++;
      last_addr = bus.wr_addr;
      last_data = bus.wr_data;
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.sdo_en === 1'b1) en_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  function automatic logic [12:0] cmd_frame(input logic [3:0] sa, input logic [7:0] op);
    return {sa, op, ~^{sa, op}};
  endfunction

  task automatic ssc();
    bus.sdi = 1'b0; #80;
    bus.sdi = 1'b1; #80;
    bus.sdi = 1'b0; #80;
  endtask

  task automatic send_bit(input logic b);
    bus.sclk = 1'b1; #30;
    bus.sdi  = b;    #50;
    bus.sclk = 1'b0; #80;
  endtask

  task automatic send_bits(input logic [12:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle_cycle();
    bus.sclk = 1'b1; #30;
    bus.sdi  = 1'b0; #50;
    bus.sclk = 1'b0; #80;
  endtask

  task automatic write_frame(input logic [3:0] sa, input logic [4:0] a,
                             input logic [7:0] d, input logic flip_par);
    logic [12:0] dw;
    ssc();
    send_bits(cmd_frame(sa, {3'b010, a}), 13);
    dw = {4'b0, d, (~^d) ^ flip_par};
    send_bits(dw, 9);
    idle_cycle();
  endtask

  task automatic peek(input logic [4:0] a, output logic [7:0] d);
    bus.dbg_addr = a; #1;
    d = bus.dbg_data; #9;
  endtask

  // Read frame with no data checks: used when no response is expected.
  task automatic read_frame_quiet(input logic [3:0] sa, input logic [4:0] a);
    ssc();
    send_bits(cmd_frame(sa, {3'b011, a}), 13);
    for (int i = 0; i < 11; i++) idle_cycle();
  endtask

  int         wr0, ferr0, en0;
  logic [7:0] d;
  logic [8:0] exp_rd;

  initial begin
    rst = 1'b1;
    bus.sclk = 1'b0;
    bus.sdi = 1'b0;
    bus.dbg_addr = 5'd0;
    #32;
    rst = 1'b0;
    #20;

    // Reset state
    check("rst_sdo",       16'(bus.sdo), 16'd0);
    check("rst_sdo_en",    16'(bus.sdo_en), 16'd0);
    check("rst_wr_vd",     16'(bus.wr_vd), 16'd0);
    check("rst_wr_addr",   16'(bus.wr_addr), 16'd0);
    check("rst_wr_data",   16'(bus.wr_data), 16'd0);
    check("rst_frame_err", 16'(bus.frame_err), 16'd0);
    peek(5'd0, d);
    check("rst_reg0", 16'(d), 16'h00);

    // Register Write SA=F addr=3 data=A5
    wr0 = wr_cnt; ferr0 = ferr_cnt; en0 = en_cnt;
    write_frame(4'hF, 5'd3, 8'hA5, 1'b0);
    check("wr_strobes",  16'(wr_cnt - wr0), 16'd1);
    check("wr_addr",     16'(last_addr), 16'd3);
    check("wr_data",     16'(last_data), 16'hA5);
    check("wr_no_sdoen", 16'(en_cnt - en0), 16'd0);
    check("wr_no_ferr",  16'(ferr_cnt - ferr0), 16'd0);
    peek(5'd3, d);
    check("wr_reg3", 16'(d), 16'hA5);
    check("wr_hold_addr", 16'(bus.wr_addr), 16'd3);

    // Register Read SA=F addr=3: TA, 1010_0101, P=1, park 0
    ferr0 = ferr_cnt;
    exp_rd = {8'hA5, 1'b1};
    ssc();
    send_bits(cmd_frame(4'hF, {3'b011, 5'd3}), 13);
    bus.sclk = 1'b1; #30; bus.sdi = 1'b0; #10;
    check("rd_ta_sdoen", 16'(bus.sdo_en), 16'd0);
    #40; bus.sclk = 1'b0; #80;
    for (int i = 8; i >= 0; i--) begin
      bus.sclk = 1'b1; #40;
      check("rd_bit",   16'(bus.sdo), 16'(exp_rd[i]));
      check("rd_sdoen", 16'(bus.sdo_en), 16'd1);
      #40; bus.sclk = 1'b0; #80;
    end
    check("rd_park_sdo",   16'(bus.sdo), 16'd0);
    check("rd_park_sdoen", 16'(bus.sdo_en), 16'd1);
    bus.sclk = 1'b1; #80; bus.sclk = 1'b0; #40;
    check("rd_release", 16'(bus.sdo_en), 16'd0);
    #40;
    check("rd_no_ferr", 16'(ferr_cnt - ferr0), 16'd0);

    // Write with flipped data parity: error, no commit
    wr0 = wr_cnt; ferr0 = ferr_cnt;
    write_frame(4'hF, 5'd7, 8'h3C, 1'b1);
    check("perr_ferr", 16'(ferr_cnt - ferr0), 16'd1);
    check("perr_no_wr", 16'(wr_cnt - wr0), 16'd0);
    peek(5'd7, d);
    check("perr_reg7", 16'(d), 16'h00);

    // Mismatched SA read and broadcast read: no response
    wr0 = wr_cnt; ferr0 = ferr_cnt; en0 = en_cnt;
    read_frame_quiet(4'h2, 5'd3);
    check("rd_sa2_sdoen", 16'(en_cnt - en0), 16'd0);
    read_frame_quiet(4'h0, 5'd3);
    check("rd_bc_sdoen", 16'(en_cnt - en0), 16'd0);
    check("rd_mis_no_wr",   16'(wr_cnt - wr0), 16'd0);
    check("rd_mis_no_ferr", 16'(ferr_cnt - ferr0), 16'd0);

    // Broadcast write addr=1 data=11
    wr0 = wr_cnt;
    write_frame(4'h0, 5'd1, 8'h11, 1'b0);
    check("bc_wr_strobe", 16'(wr_cnt - wr0), 16'd1);
    check("bc_wr_addr", 16'(last_addr), 16'd1);
    peek(5'd1, d);
    check("bc_reg1", 16'(d), 16'h11);

    // Abort after 6 command bits, then a full write addr=2 data=5A
    wr0 = wr_cnt; ferr0 = ferr_cnt;
    ssc();
    send_bits(cmd_frame(4'hF, {3'b010, 5'd9}), 13 - 7 + 0);
    check("abort_pre_ferr", 16'(ferr_cnt - ferr0), 16'd0);
    ssc();
    check("abort_ferr", 16'(ferr_cnt - ferr0), 16'd1);
    send_bits(cmd_frame(4'hF, {3'b010, 5'd2}), 13);
    send_bits({4'b0, 8'h5A, ~^8'h5A}, 9);
    idle_cycle();
    check("abort_wr_strobe", 16'(wr_cnt - wr0), 16'd1);
    check("abort_ferr_once", 16'(ferr_cnt - ferr0), 16'd1);
    peek(5'd2, d);
    check("abort_reg2", 16'(d), 16'h5A);
    peek(5'd9, d);
    check("abort_reg9", 16'(d), 16'h00);

    // Command 8'b1_1010101 SA=F
    wr0 = wr_cnt;
    ssc();
    send_bits(cmd_frame(4'hF, 8'b1101_0101), 13);
    idle_cycle();
    peek(5'd0, d);
`ifdef RFFE_REG0_WR_EN
    check("reg0_strobe", 16'(wr_cnt - wr0), 16'd1);
    check("reg0_addr", 16'(last_addr), 16'd0);
    check("reg0_data", 16'(last_data), 16'h55);
    check("reg0_val", 16'(d), 16'h55);
`else
    check("reg0_strobe", 16'(wr_cnt - wr0), 16'd0);
    check("reg0_val", 16'(d), 16'h00);
`endif

    // Reset asserted mid-read releases sdo_en without a clk edge
    ssc();
    send_bits(cmd_frame(4'hF, {3'b011, 5'd3}), 13);
    idle_cycle();
    for (int i = 0; i < 2; i++) begin
      bus.sclk = 1'b1; #80; bus.sclk = 1'b0; #80;
    end
    check("mid_rd_sdoen", 16'(bus.sdo_en), 16'd1);
    rst = 1'b1; #1;
    check("async_rst_sdoen", 16'(bus.sdo_en), 16'd0);
    #19;
    rst = 1'b0;
    #80;
    peek(5'd3, d);
    check("rst_clears_reg3", 16'(d), 16'h00);

    // First frame after reset with a full SSC
    wr0 = wr_cnt;
    write_frame(4'hF, 5'd4, 8'h77, 1'b0);
    check("post_rst_wr", 16'(wr_cnt - wr0), 16'd1);
    peek(5'd4, d);
    check("post_rst_reg4", 16'(d), 16'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rffe_slave.md
RFFE_SLAVE -- requirements
Module: rffe_slave

Interface
REQ-001 Parameter USID, default 4'hF, unique slave ID matched against the command-frame SA field.
REQ-002 Parameter SYNC_STAGES, default 2, flops in the sclk/sdi input synchronizers (legal 2..3).
REQ-003 clk  input  1  system clock; every flop is clocked by clk.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 sclk  input  1  MIPI RFFE bus clock from master; asynchronous to clk; clk SHALL be at least 8x sclk.
REQ-006 sdi  input  1  SDATA as seen on the pad.
REQ-007 sdo  output  1  SDATA drive value.
REQ-008 sdo_en  output  1  SDATA output enable; pad tristated when 0.
REQ-009 wr_vd  output  1  one-clk strobe: register write committed.
REQ-010 wr_addr  output  5  address of committed write.
REQ-011 wr_data  output  8  data of committed write.
REQ-012 frame_err  output  1  one-clk strobe: parity error or aborted frame.
REQ-013 dbg_addr  input  5  host-side register inspect address.
REQ-014 dbg_data  output  8  combinational read of regfile[dbg_addr].

Function
REQ-015 sclk and sdi SHALL each pass through SYNC_STAGES flops; rise/fall events are one-clk pulses from the last two stages.
REQ-016 Internal 32x8 register file; addr 0 is REG0.
REQ-017 FSM states: IDLE, SSC, CMD, WDATA, TA, RDATA, PARK.
REQ-018 IDLE->SSC on synced sdi rise while synced sclk low; SSC->CMD on synced sdi fall while sclk low; sclk rise during SSC -> IDLE.
REQ-019 CMD shifts 13 bits on synced sclk fall, MSB first: SA[3:0], CMD[7:0], P; P SHALL make odd parity over all 13 bits.
REQ-020 Match: SA==USID, or SA==0 for write commands only; no match -> IDLE without any output activity.
REQ-021 CMD[7:5]==3'b010 Register Write, addr=CMD[4:0]; CMD[7:5]==3'b011 Register Read, addr=CMD[4:0]; all other encodings ignored -> IDLE (except REQ-034).
REQ-022 Write: WDATA shifts 9 bits (D[7:0], P odd over 9 bits); good parity -> regfile[addr] updated and wr_vd/wr_addr/wr_data asserted one clk after the sclk fall sampling P; then PARK.
REQ-023 Read: after CMD parity, TA spans one sclk period with sdo_en=0; RDATA drives D[7:0] then odd parity P, each bit updated one clk after synced sclk rise.
REQ-024 After the sclk fall sampling RDATA P, sdo=0 with sdo_en=1 until the next sclk fall (bus park), then sdo_en=0 and state IDLE.
REQ-025 PARK for writes: wait one sclk fall, then IDLE.
REQ-026 Parity error in CMD or WDATA -> frame_err one clk, no write, no read response, IDLE.
REQ-027 New SSC detected in any state other than IDLE/RDATA/PARK -> frame_err one clk, restart at SSC (abort).
REQ-028 sdo_en SHALL be 1 only in RDATA and the read park half; it never asserts in write frames.
REQ-029 wr_addr/wr_data hold their last values between strobes.

Reset
REQ-030 On rst: state IDLE, synchronizers 0, sdo=0, sdo_en=0, wr_vd=0, wr_addr=0, wr_data=0, frame_err=0, regfile all 8'h00.
REQ-031 rst asserted mid-read SHALL release sdo_en asynchronously, same clk edge independent.
REQ-032 After rst deassert, first frame accepted only after a full SSC.

Configuration
REQ-033 Macro RFFE_REG0_WR_EN compiles in the Register 0 Write command.
REQ-034 With RFFE_REG0_WR_EN defined: CMD[7]==1 commits REG0=CMD[6:0] (bit7 cleared), wr_vd with wr_addr=0, one clk after CMD P sample, then PARK; undefined: CMD[7]==1 treated as unsupported, ignored, no write.

Verification
REQ-035 Reset, USID=4'hF; SSC, Register Write SA=F addr=5'h03 data=8'hA5, correct parity -> wr_vd=1, wr_addr=3, wr_data=A5, dbg_data(3)=A5, sdo_en never 1.
REQ-036 Following write, Register Read SA=F addr=3 -> sdo_en high after TA, serial 1010_0101 then P=1, park 0, sdo_en low; frame_err=0.
REQ-037 Register Write addr=5'h07 data=8'h3C with flipped data parity -> frame_err pulse, no wr_vd, dbg_data(7)=00.
REQ-038 Register Read SA=4'h2 (mismatch) and broadcast SA=0 read -> sdo_en stays 0, no strobes; broadcast SA=0 write addr=1 data=8'h11 -> wr_vd, regfile[1]=11.
REQ-039 New SSC inserted after 6 CMD bits -> frame_err one clk, subsequent full write addr=2 data=8'h5A commits normally.
REQ-040 Command 8'b1_1010101 SA=F: with RFFE_REG0_WR_EN -> wr_vd, wr_addr=0, wr_data=8'h55; without -> no wr_vd, REG0 unchanged.
